// File: rtl/arith_cmd_sequencer.sv
// Command FIFO and issue/capture sequencer for the registered arithmetic unit.
// Optional result/status parity checker: define ARITH_SEQ_PARITY_CHECK_EN.
module arith_cmd_sequencer #(
  parameter int WIDTH_M = 4,
  parameter int WIDTH_N = 2,
  parameter int DEPTH   = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [WIDTH_N-1:0] i_cmd_op,
  input  logic [WIDTH_M-1:0] i_cmd_A,
  input  logic [WIDTH_M-1:0] i_cmd_B,
  output logic [WIDTH_N-1:0] o_op,
  output logic [WIDTH_M-1:0] o_arg_A,
  output logic [WIDTH_M-1:0] o_arg_B,
  input  logic [WIDTH_M-1:0] i_result,
  input  logic [3:0]         i_status,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [WIDTH_N-1:0] o_rsp_op,
  output logic [WIDTH_M-1:0] o_rsp_result,
  output logic [3:0]         o_rsp_status,
  output logic [7:0]         o_err_count,
  output logic               o_busy,
  output logic               o_parity_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH_N + 2 * WIDTH_M;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

`ifdef ARITH_SEQ_PARITY_CHECK_EN
  function automatic logic xor_reduce(input logic [WIDTH_M-1:0] v);
    return ^v;
  endfunction
`endif

  state_t               state_q, state_d;
  logic [EW-1:0]        mem_q [DEPTH];
  logic [EW-1:0]        mem_d [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH_N-1:0]   op_q, op_d, rsp_op_q, rsp_op_d;
  logic [WIDTH_M-1:0]   arg_a_q, arg_a_d, arg_b_q, arg_b_d, rsp_result_q, rsp_result_d;
  logic [3:0]           rsp_status_q, rsp_status_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [7:0]           err_count_q, err_count_d;
  logic                 parity_err_q, parity_err_d;
  logic                 full_s, empty_s, push_s, pop_s;

  assign full_s      = (count_q == CNT_FULL);
  assign empty_s     = (count_q == '0);
  assign o_cmd_ready = ~full_s & i_reset;
  assign push_s      = i_cmd_valid & o_cmd_ready;
  assign pop_s       = (state_q == IDLE) & ~empty_s;

  // Next-state for FIFO, sequencer FSM and response/statistics registers.
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    op_d         = op_q;
    arg_a_d      = arg_a_q;
    arg_b_d      = arg_b_q;
    rsp_op_d     = rsp_op_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;
    rsp_valid_d  = rsp_valid_q;
    err_count_d  = err_count_q;
    parity_err_d = parity_err_q;

    if (push_s) begin
      mem_d[wr_ptr_q] = {i_cmd_op, i_cmd_A, i_cmd_B};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          {op_d, arg_a_d, arg_b_d} = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          state_d  = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        rsp_op_d     = op_q;
        rsp_result_d = i_result;
        rsp_status_d = i_status;
        rsp_valid_d  = 1'b1;
        if (i_status[3] && (err_count_q != 8'hFF)) begin
          err_count_d = err_count_q + 8'd1;
        end else begin
          err_count_d = err_count_q;
        end
`ifdef ARITH_SEQ_PARITY_CHECK_EN
        // Result is undefined on ERROR, so parity is only meaningful without it.
        if (!i_status[3] && (xor_reduce(i_result) != i_status[2])) begin
          parity_err_d = 1'b1;
        end else begin
          parity_err_d = parity_err_q;
        end
`endif
        state_d = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      op_q         <= '0;
      arg_a_q      <= '0;
      arg_b_q      <= '0;
      rsp_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_status_q <= 4'd0;
      rsp_valid_q  <= 1'b0;
      err_count_q  <= 8'd0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      op_q         <= op_d;
      arg_a_q      <= arg_a_d;
      arg_b_q      <= arg_b_d;
      rsp_op_q     <= rsp_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
      rsp_valid_q  <= rsp_valid_d;
      err_count_q  <= err_count_d;
      parity_err_q <= parity_err_d;
    end
  end

  // FIFO storage; contents are only meaningful under the count, so no reset.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_op         = op_q;
  assign o_arg_A      = arg_a_q;
  assign o_arg_B      = arg_b_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_op     = rsp_op_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_status = rsp_status_q;
  assign o_err_count  = err_count_q;
  assign o_busy       = (state_q != IDLE) | ~empty_s;
`ifdef ARITH_SEQ_PARITY_CHECK_EN
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_arith_cmd_sequencer.sv
// Directed self-checking bench for arith_cmd_sequencer with a registered
// behavioural model of the arithmetic unit on the operand/result side.
module tb_arith_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy, parity_err;
  logic [1:0] cmd_op, u_op, rsp_op;
  logic [3:0] cmd_a, cmd_b, u_a, u_b, rsp_result, rsp_status;
  logic [3:0] u_result, u_status, dut_result, dut_status;
  logic [3:0] ovr_result, ovr_status;
  logic       ovr_en;
  logic [7:0] err_count;
  int         errors = 0;
  int         checks = 0;

`ifdef ARITH_SEQ_PARITY_CHECK_EN
  localparam logic EXP_PAR = 1'b1;
`else
  localparam logic EXP_PAR = 1'b0;
`endif

  always #5 clk = ~clk;

  arith_cmd_sequencer dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_A(cmd_a), .i_cmd_B(cmd_b),
    .o_op(u_op), .o_arg_A(u_a), .o_arg_B(u_b),
    .i_result(dut_result), .i_status(dut_status),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_op(rsp_op), .o_rsp_result(rsp_result), .o_rsp_status(rsp_status),
    .o_err_count(err_count), .o_busy(busy), .o_parity_err(parity_err)
  );

  // Arithmetic unit: 00 shift A<<B, 10 divide B/A, 11 sign-magnitude to two's complement.
  function automatic logic [7:0] unit_model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] wide;
    logic [3:0] r;
    logic [3:0] st;
    r = 4'b0000; st = 4'b0000; wide = 8'h00;
    case (op)
      2'b00: begin wide = {4'b0000, a} << b; r = wide[3:0]; st[0] = |wide[7:4]; end
      2'b10: if (a == 4'b0000) st = 4'b1000; else r = b / a;
      2'b11: if (a == 4'b1000) st = 4'b1001;
             else if (a[3]) r = 4'b0000 - {1'b0, a[2:0]};
             else r = a;
      default: r = 4'b0000;
    endcase
    if (!st[3]) begin st[2] = ^r; st[1] = &r; end
    return {st, r};
  endfunction

  always_ff @(posedge clk) {u_status, u_result} <= unit_model(u_op, u_a, u_b);

  assign dut_result = ovr_en ? ovr_result : u_result;
  assign dut_status = ovr_en ? ovr_status : u_status;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for a response, compares it inline, then takes it.
  task automatic expect_rsp(input string name, input logic [1:0] op, input logic [3:0] res, input logic [3:0] st);
    int n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s_timeout: rsp_valid=%b required 1", name, rsp_valid); end
    checks++;
    if ({rsp_op, rsp_result, rsp_status} !== {op, res, st}) begin
      errors++;
      $display("FAIL %s_rsp: op=%b result=%b status=%b required op=%b result=%b status=%b",
               name, rsp_op, rsp_result, rsp_status, op, res, st);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s_release: rsp_valid=%b required 0", name, rsp_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({u_op, u_a, u_b, rsp_valid, rsp_op, rsp_result, rsp_status, err_count, busy, parity_err, cmd_ready} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: op=%b A=%b B=%b rv=%b rop=%b rres=%b rst=%b err=%0d busy=%b par=%b rdy=%b required all 0",
               u_op, u_a, u_b, rsp_valid, rsp_op, rsp_result, rsp_status, err_count, busy, parity_err, cmd_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL reset_release: ready=%b busy=%b required 1 0", cmd_ready, busy); end
  endtask

  // Shift command with the push-to-response latency checked cycle by cycle.
  task automatic test_shift_latency(input string name);
    push(2'b00, 4'b0011, 4'b0001);
    tick();
    checks++;
    if ({u_op, u_a, u_b, busy, rsp_valid} !== {2'b00, 4'b0011, 4'b0001, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s_issue: op=%b A=%b B=%b busy=%b rv=%b required 00 0011 0001 1 0", name, u_op, u_a, u_b, busy, rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s_early: rsp_valid=%b required 0 at push+2", name, rsp_valid); end
    tick();
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s_latency: rsp_valid=%b required 1 at push+3", name, rsp_valid); end
    expect_rsp(name, 2'b00, 4'b0110, 4'b0000);
  endtask

  task automatic test_err_count();
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL err_initial: err_count=%0d required 0", err_count); end
    push(2'b11, 4'b1000, 4'b0000);
    expect_rsp("zm_err1", 2'b11, 4'b0000, 4'b1001);
    checks++;
    if (err_count !== 8'd1) begin errors++; $display("FAIL err_one: err_count=%0d required 1", err_count); end
    push(2'b11, 4'b1000, 4'b0000);
    expect_rsp("zm_err2", 2'b11, 4'b0000, 4'b1001);
    checks++;
    if (err_count !== 8'd2) begin errors++; $display("FAIL err_two: err_count=%0d required 2", err_count); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 253; i++) begin
      push(2'b11, 4'b1000, 4'b0000);
      repeat (4) tick();
    end
    rsp_ready = 1'b0;
    checks++;
    if (err_count !== 8'd255) begin errors++; $display("FAIL err_255: err_count=%0d required 255", err_count); end
    push(2'b11, 4'b1000, 4'b0000);
    expect_rsp("zm_err_sat", 2'b11, 4'b0000, 4'b1001);
    checks++;
    if (err_count !== 8'd255) begin errors++; $display("FAIL err_saturate: err_count=%0d required 255", err_count); end
  endtask

  task automatic test_normal_ops();
    push(2'b11, 4'b1011, 4'b0000);
    expect_rsp("zm_norm", 2'b11, 4'b1101, 4'b0100);
    push(2'b10, 4'b0101, 4'b1101);
    expect_rsp("divide", 2'b10, 4'b0010, 4'b0100);
    checks++;
    if ({err_count, parity_err} !== {8'd255, 1'b0}) begin
      errors++; $display("FAIL normal_stats: err_count=%0d parity=%b required 255 0", err_count, parity_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] bs [6];
    logic [3:0] as [6];
    logic [3:0] rs [5];
    logic [3:0] ss [5];
    as = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0011};
    bs = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0000, 4'b0001};
    rs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011};
    ss = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = as[i]; cmd_b = bs[i];
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_accept%0d: cmd_ready=%b required 1", i, cmd_ready); end
      tick();
    end
    cmd_a = as[5]; cmd_b = bs[5];
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({cmd_ready, rsp_valid, rsp_op, rsp_result, rsp_status} !== {1'b0, 1'b1, 2'b00, 4'b0001, 4'b0100}) begin
        errors++;
        $display("FAIL bp_hold%0d: ready=%b rv=%b op=%b res=%b st=%b required 0 1 00 0001 0100",
                 c, cmd_ready, rsp_valid, rsp_op, rsp_result, rsp_status);
      end
      tick();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) expect_rsp($sformatf("drain%0d", i), 2'b00, rs[i], ss[i]);
    repeat (4) tick();
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("FAIL bp_empty: busy=%b rv=%b required 0 0", busy, rsp_valid); end
  endtask

  task automatic test_parity();
    ovr_en = 1'b1; ovr_result = 4'b0001; ovr_status = 4'b0000;
    push(2'b00, 4'b0000, 4'b0000);
    expect_rsp("par_force", 2'b00, 4'b0001, 4'b0000);
    ovr_en = 1'b0;
    checks++;
    if (parity_err !== EXP_PAR) begin errors++; $display("FAIL parity_set: parity_err=%b required %b", parity_err, EXP_PAR); end
    push(2'b00, 4'b0001, 4'b0001);
    expect_rsp("par_after", 2'b00, 4'b0010, 4'b0100);
    checks++;
    if (parity_err !== EXP_PAR) begin errors++; $display("FAIL parity_sticky: parity_err=%b required %b", parity_err, EXP_PAR); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    push(2'b00, 4'b0001, 4'b0001);
    push(2'b00, 4'b0001, 4'b0010);
    push(2'b00, 4'b0001, 4'b0011);
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: cmd_ready=%b required 0", cmd_ready); end
    tick();
    checks++;
    if ({u_op, u_a, u_b, rsp_valid, rsp_op, rsp_result, rsp_status, err_count, busy, parity_err} !== 36'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: op=%b A=%b B=%b rv=%b rop=%b rres=%b rst=%b err=%0d busy=%b par=%b required all 0",
               u_op, u_a, u_b, rsp_valid, rsp_op, rsp_result, rsp_status, err_count, busy, parity_err);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL rstmid_quiet%0d: rv=%b busy=%b required 0 0", c, rsp_valid, busy); end
    end
    rsp_ready = 1'b0;
    test_shift_latency("post_reset");
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 4'b0000; cmd_b = 4'b0000;
    rsp_ready = 1'b0; ovr_en = 1'b0; ovr_result = 4'b0000; ovr_status = 4'b0000;
    rst_n = 1'b0;
    tick();
    test_reset();
    test_shift_latency("shift");
    test_err_count();
    test_normal_ops();
    test_back_to_back();
    test_parity();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
